// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the RV32I datapath.
// The master side is the sequencer; the slave side is the datapath and memories.
interface multicycle_ctrl_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 branch;
    logic                 imem_ready;
    logic                 dmem_ready;
    logic                 imem_req;
    logic                 ir_we;
    logic                 dmem_req;
    logic                 dmem_we;
    logic                 rf_we;
    logic [1:0]           wb_sel;
    logic                 pc_we;
    logic [1:0]           pc_sel;
    logic                 illegal;
    logic [2:0]           state;
    logic [INSTRET_W-1:0] instret;

    // Handshake: a request (imem_req/dmem_req) is held high until the matching ready
    // is seen high in the same cycle; that cycle is the transfer and the state advances.
    modport master (
        input  opcode, funct3, branch, imem_ready, dmem_ready,
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
               pc_we, pc_sel, illegal, state, instret
    );

    modport slave (
        output opcode, funct3, branch, imem_ready, dmem_ready,
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
               pc_we, pc_sel, illegal, state, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a sticky trap
// on illegal encodings and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t               state_q, state_d;
    logic [INSTRET_W-1:0] instret_q;
    logic                 legal;
    logic                 retire;
    logic                 imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
    logic [1:0]           wb_sel, pc_sel;

    always_comb begin
        legal = 1'b0;
        case (bus.opcode)
            OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            OP_LOAD:   legal = (bus.funct3 != 3'd3) && (bus.funct3 != 3'd6) && (bus.funct3 != 3'd7);
            OP_STORE:  legal = (bus.funct3 <= 3'd2);
            OP_BRANCH: legal = (bus.funct3 != 3'd2) && (bus.funct3 != 3'd3);
            default:   legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // Moore-style decode; ready/branch only qualify the transfer cycle of the current state.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        wb_sel   = 2'd0;
        pc_sel   = 2'd0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                if (bus.opcode == OP_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = bus.branch ? 2'd1 : 2'd0;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (bus.opcode == OP_STORE);
                if (bus.dmem_ready) begin
                    if (bus.opcode == OP_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                case (bus.opcode)
                    OP_LOAD: wb_sel = 2'd1;
                    OP_JAL: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd1;
                    end
                    OP_JALR: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd2;
                    end
                    default: begin
                        wb_sel = 2'd0;
                        pc_sel = 2'd0;
                    end
                endcase
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.imem_req = imem_req;
    assign bus.ir_we    = ir_we;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.rf_we    = rf_we;
    assign bus.wb_sel   = wb_sel;
    assign bus.pc_we    = pc_we;
    assign bus.pc_sel   = pc_sel;
    assign bus.illegal  = (state_q == S_TRAP);
    assign bus.state    = state_q;
    assign bus.instret  = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, random instruction
// stream against a phase-count reference model, trap and asynchronous-reset sequences.
module tb_multicycle_ctrl;
    localparam int W = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_ctrl_if #(.INSTRET_W(W)) bus ();
    multicycle_ctrl #(.INSTRET_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_instret = 0;

    int obs_cyc, obs_imem, obs_ir, obs_dmem, obs_dwe, obs_rf, obs_pc;
    int obs_pc_sel, obs_wb_sel, obs_rf_last;
    bit obs_done, obs_trap;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       br;
        int         iw;
        int         dw;
        int         cyc;
        int         rf;
        int         wb;
        int         pc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            OP_LOAD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            OP_STORE:  return f3 inside {3'd0, 3'd1, 3'd2};
            OP_BRANCH: return !(f3 inside {3'd2, 3'd3});
            default:   return 1'b0;
        endcase
    endfunction

    function automatic int outs_vec();
        return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc_we,
                bus.wb_sel, bus.pc_sel, bus.illegal, bus.state, bus.instret};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        bus.opcode = 7'd0;
        bus.funct3 = 3'd0;
        bus.branch = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_outputs_zero", outs_vec(), 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        chk("idle_no_imem_req", int'(bus.imem_req), 0);
        chk("idle_state", int'(bus.state), 0);
        @(negedge clk);
        #1;
        chk("first_imem_req", int'(bus.imem_req), 1);
        chk("rst_instret", int'(bus.instret), 0);
        exp_instret = 0;
    endtask

    // Runs one instruction; assumes the DUT is in its first (fetch) cycle now.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                             input int iw, input int dw);
        int iwl = iw;
        int dwl = dw;
        bus.opcode = op;
        bus.funct3 = f3;
        bus.branch = br;
        obs_cyc = 0; obs_imem = 0; obs_ir = 0; obs_dmem = 0; obs_dwe = 0;
        obs_rf = 0; obs_pc = 0; obs_pc_sel = -1; obs_wb_sel = -1; obs_rf_last = 0;
        obs_done = 0; obs_trap = 0;
        while (!obs_done && obs_cyc < 64) begin
            bus.imem_ready = (iwl == 0);
            bus.dmem_ready = (dwl == 0);
            #1;
            obs_cyc++;
            obs_imem += int'(bus.imem_req);
            obs_ir   += int'(bus.ir_we);
            obs_dmem += int'(bus.dmem_req);
            obs_dwe  += int'(bus.dmem_we);
            obs_rf   += int'(bus.rf_we);
            if (bus.rf_we) obs_wb_sel = int'(bus.wb_sel);
            if (bus.imem_req && !bus.imem_ready) iwl--;
            if (bus.dmem_req && !bus.dmem_ready) dwl--;
            if (bus.pc_we) begin
                obs_pc++;
                obs_pc_sel  = int'(bus.pc_sel);
                obs_rf_last = int'(bus.rf_we);
                obs_done    = 1;
            end
            if (bus.state == 3'd6) begin
                obs_trap = 1;
                obs_done = 1;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_model(input logic [6:0] op, input logic [2:0] f3, input logic br,
                               input int iw, input int dw);
        bit mem     = (op == OP_LOAD) || (op == OP_STORE);
        bit writes  = !((op == OP_BRANCH) || (op == OP_STORE));
        int exp_cyc = (iw + 1) + 1 + 1 + (mem ? dw + 1 : 0) + (writes ? 1 : 0);
        int exp_pc  = (op == OP_BRANCH) ? int'(br) : (op == OP_JAL) ? 1 : (op == OP_JALR) ? 2 : 0;
        int exp_wb  = (op == OP_LOAD) ? 1 : (op == OP_JAL || op == OP_JALR) ? 2 : 0;
        exp_instret++;
        chk("completed", int'(obs_done && !obs_trap), 1);
        chk("cycles", obs_cyc, exp_cyc);
        chk("imem_req_cycles", obs_imem, iw + 1);
        chk("ir_we_pulses", obs_ir, 1);
        chk("dmem_req_cycles", obs_dmem, mem ? dw + 1 : 0);
        chk("dmem_we_cycles", obs_dwe, (op == OP_STORE) ? dw + 1 : 0);
        chk("rf_we_pulses", obs_rf, writes ? 1 : 0);
        chk("pc_we_pulses", obs_pc, 1);
        chk("pc_sel", obs_pc_sel, exp_pc);
        if (writes) begin
            chk("wb_sel", obs_wb_sel, exp_wb);
            chk("rf_we_with_pc_we", obs_rf_last, 1);
        end
        chk("instret", int'(bus.instret), exp_instret % (1 << W));
    endtask

    task automatic trap_hold(input string tag);
        int bad_state = 0;
        int bad_en = 0;
        int bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.imem_ready = 1'($urandom_range(0, 1));
            bus.dmem_ready = 1'($urandom_range(0, 1));
            bus.branch     = 1'($urandom_range(0, 1));
            #1;
            if (bus.state != 3'd6 || !bus.illegal) bad_state++;
            if ({bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc_we} != 6'd0)
                bad_en++;
            if (int'(bus.instret) != exp_instret % (1 << W)) bad_cnt++;
            @(negedge clk);
        end
        chk({tag, "_sticky"}, bad_state, 0);
        chk({tag, "_enables_off"}, bad_en, 0);
        chk({tag, "_instret_frozen"}, bad_cnt, 0);
    endtask

    initial begin
        logic [6:0] ops[9];
        logic [2:0] ld_f3[5];
        logic [2:0] br_f3[6];
        int         k;
        bit         seen;
        int         pulses;

        ops   = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        //          op         f3  br iw dw cyc rf wb pc
        vecs[0]  = '{OP_R,      3'd0, 1'b0, 0, 0, 4, 1, 0, 0};
        vecs[1]  = '{OP_LOAD,   3'd2, 1'b0, 0, 2, 7, 1, 1, 0};
        vecs[2]  = '{OP_BRANCH, 3'd0, 1'b1, 0, 0, 3, 0, 0, 1};
        vecs[3]  = '{OP_BRANCH, 3'd0, 1'b0, 0, 0, 3, 0, 0, 0};
        vecs[4]  = '{OP_STORE,  3'd2, 1'b0, 1, 1, 6, 0, 0, 0};
        vecs[5]  = '{OP_JAL,    3'd0, 1'b0, 2, 0, 6, 1, 2, 1};
        vecs[6]  = '{OP_JALR,   3'd0, 1'b0, 0, 0, 4, 1, 2, 2};
        vecs[7]  = '{OP_LUI,    3'd3, 1'b0, 0, 3, 4, 1, 0, 0};
        vecs[8]  = '{OP_AUIPC,  3'd0, 1'b1, 0, 0, 4, 1, 0, 0};
        vecs[9]  = '{OP_I,      3'd0, 1'b0, 0, 0, 4, 1, 0, 0};
        vecs[10] = '{OP_LOAD,   3'd0, 1'b0, 0, 0, 5, 1, 1, 0};
        vecs[11] = '{OP_BRANCH, 3'd1, 1'b1, 3, 0, 6, 0, 0, 1};

        bus.opcode = 7'd0;
        bus.funct3 = 3'd0;
        bus.branch = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;

        do_reset();

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].br, vecs[i].iw, vecs[i].dw);
            chk($sformatf("vec%0d_cycles", i), obs_cyc, vecs[i].cyc);
            chk($sformatf("vec%0d_rf_we", i), obs_rf, vecs[i].rf);
            chk($sformatf("vec%0d_pc_sel", i), obs_pc_sel, vecs[i].pc);
            if (vecs[i].rf != 0) chk($sformatf("vec%0d_wb_sel", i), obs_wb_sel, vecs[i].wb);
            check_model(vecs[i].op, vecs[i].f3, vecs[i].br, vecs[i].iw, vecs[i].dw);
        end

        // Random legal stream; more than 2^W retirements so instret wraps.
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       br;
            int         iw, dw;
            op = ops[$urandom_range(0, 8)];
            case (op)
                OP_LOAD:   f3 = ld_f3[$urandom_range(0, 4)];
                OP_STORE:  f3 = 3'($urandom_range(0, 2));
                OP_BRANCH: f3 = br_f3[$urandom_range(0, 5)];
                default:   f3 = 3'($urandom_range(0, 7));
            endcase
            br = 1'($urandom_range(0, 1));
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            if (!is_legal(op, f3)) chk("rand_gen_legal", 0, 1);
            run_instr(op, f3, br, iw, dw);
            check_model(op, f3, br, iw, dw);
        end

        // Illegal SYSTEM opcode traps permanently.
        do_reset();
        run_instr(7'b1110011, 3'd0, 1'b0, 1, 0);
        chk("sys_trap_entered", int'(obs_trap), 1);
        chk("sys_trap_no_rf", obs_rf, 0);
        chk("sys_trap_no_pc", obs_pc, 0);
        trap_hold("sys_trap");
        do_reset();
        chk("trap_cleared", int'(bus.illegal), 0);

        // STORE with reserved funct3 traps too.
        run_instr(OP_STORE, 3'd3, 1'b0, 0, 0);
        chk("st3_trap_entered", int'(obs_trap), 1);
        chk("st3_no_dmem", obs_dmem, 0);
        trap_hold("st3_trap");

        // Reset asserted while a store waits in MEM.
        do_reset();
        bus.opcode = OP_STORE;
        bus.funct3 = 3'd1;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        seen = 0;
        pulses = 0;
        k = 0;
        while (!seen && k < 20) begin
            #1;
            pulses += int'(bus.rf_we) + int'(bus.pc_we);
            if (bus.dmem_req) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("mem_reached", int'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dmem_req_drop", int'(bus.dmem_req), 0);
        chk("async_state_idle", int'(bus.state), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            pulses += int'(bus.rf_we) + int'(bus.pc_we);
        end
        rst_n = 1'b1;
        #1;
        chk("abort_no_writes", pulses, 0);
        chk("abort_instret", int'(bus.instret), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
